mem_stage_sram_ctrl: RTL and testbench

MEM-stage data-memory access unit, sitting between the EX stage register and the MEM stage register. It converts a single 32-bit load or store from the EX register into two 16-bit accesses to the external asynchronous SRAM, then hands the read word to the MEM stage register. While an access is in flight it holds `ready` low; the pipeline uses `ready` as its freeze source.

---
 rtl/mem_stage_pkg.sv | 20 ++
 rtl/sram_phase_timer.sv | 38 +++
 rtl/mem_stage_sram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage SRAM access unit.
//   state_e           : access FSM states
//   SRAM_AW / SRAM_DW : external SRAM halfword address and data widths
//   DEFAULT_BASE_ADDR : byte address that maps to SRAM word 0
//   CNT_W             : phase timer width (covers WAIT_CYCLES up to 15)
package mem_stage_pkg;

  localparam int unsigned SRAM_AW           = 18;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned DEFAULT_BASE_ADDR = 1024;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing one 16-bit SRAM phase.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   load     : reload the counter with load_val (phase entry)
//   load_val : cycles-per-phase minus one
//   last     : high on the final cycle of the current phase
module sram_phase_timer
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory access unit: splits one 32-bit load/store into two
// 16-bit accesses (LO then HI halfword) on an asynchronous SRAM and holds
// ready low while the access is in flight.
// Optional feature macro: SRAM_RANGE_CHECK_EN (out-of-range addresses go
// straight to DONE with err=1 and no SRAM strobes; otherwise they wrap).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   mem_r_en, mem_w_en  : load / store request (store wins if both)
//   addr, wdata         : byte address, store data
//   rdata               : load data
//   ready               : low while an access is in progress
//   err                 : one-cycle out-of-range flag
//   sram_addr           : SRAM halfword address (registered)
//   sram_dq_o/_oe/_i    : SRAM data out, drive enable, data in
//   sram_we_n, sram_oe_n: SRAM write strobe / output enable, active-low
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(WAIT_CYCLES - 1);

  state_e state_q, state_d;

  logic               req, range_err, last, timer_load;
  logic [31:0]        off;
  logic [SRAM_AW-2:0] widx_q, widx_sel;
  logic [31:0]        wdata_q, wdata_sel;
  logic               is_wr_q, is_wr_sel;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0] dq_o_q, dq_o_d;
  logic               dq_oe_q, dq_oe_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic               unused_off_bits;

  assign req = mem_r_en | mem_w_en;
  assign off = addr - BASE_ADDR;
  // Byte offset within a word is don't-care; high bits matter only with range check.
  assign unused_off_bits = ^{off[31:19], off[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
  assign range_err = (off[31:19] != '0);
`else
  assign range_err = 1'b0;
`endif

  sram_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LoadVal),
    .last     (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = range_err ? StDone : StLo;
      StLo:    if (last) state_d = StHi;
      StHi:    if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign timer_load = (state_d != state_q) && ((state_d == StLo) || (state_d == StHi));

  // In IDLE the request fields are not latched yet, so the registered SRAM
  // outputs for the first LO cycle come straight from the inputs.
  always_comb begin
    widx_sel  = widx_q;
    wdata_sel = wdata_q;
    is_wr_sel = is_wr_q;
    if (state_q == StIdle) begin
      widx_sel  = off[SRAM_AW:2];
      wdata_sel = wdata;
      is_wr_sel = mem_w_en;
    end
  end

  // Outputs: ready is combinational; SRAM signals are computed for the
  // next state and registered.
  always_comb begin
    ready       = ((state_q == StIdle) && !req) || (state_q == StDone);
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    if ((state_d == StLo) || (state_d == StHi)) begin
      sram_addr_d = {widx_sel, state_d == StHi};
      if (is_wr_sel) begin
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        dq_o_d  = (state_d == StHi) ? wdata_sel[31:16] : wdata_sel[15:0];
      end else begin
        oe_n_d = 1'b0;
      end
    end

    rdata_d = rdata_q;
    if ((state_q == StLo) && last && !is_wr_q) rdata_d[15:0] = sram_dq_i;
    if ((state_q == StHi) && last && !is_wr_q) rdata_d[31:16] = sram_dq_i;
    if ((state_q == StIdle) && req && range_err && !mem_w_en) rdata_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      if ((state_q == StIdle) && req) begin
        widx_q  <= off[SRAM_AW:2];
        wdata_q <= wdata;
        is_wr_q <= mem_w_en;
      end
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

`ifdef SRAM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == StIdle) && req && range_err;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rdata      = rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: lane 0 uses WAIT_CYCLES=2, lane 1 uses
// WAIT_CYCLES=1. Each lane has an SRAM model and a transaction-level
// reference model compared against the DUT on every falling edge.
module tb_mem_stage_sram_ctrl;

  logic        clk, rst;
  logic        mem_r_en [2];
  logic        mem_w_en [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        err      [2];
  logic [17:0] sram_addr[2];
  logic [15:0] dq_o     [2];
  logic [15:0] dq_i     [2];
  logic        dq_oe    [2];
  logic        we_n     [2];
  logic        oe_n     [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent access() call
  int          n_low, n_wr, n_rd;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] tr_addr[$];
  logic [31:0] tr_dq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int lane, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h at %0t", nm, lane, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int W  = (g == 0) ? 2 : 1;
    localparam int TD = 2 * W + 1;

    mem_stage_sram_ctrl #(
      .BASE_ADDR   (1024),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en[g]),
      .mem_w_en   (mem_w_en[g]),
      .addr       (addr[g]),
      .wdata      (wdata[g]),
      .rdata      (rdata[g]),
      .ready      (ready[g]),
      .err        (err[g]),
      .sram_addr  (sram_addr[g]),
      .sram_dq_o  (dq_o[g]),
      .sram_dq_oe (dq_oe[g]),
      .sram_dq_i  (dq_i[g]),
      .sram_we_n  (we_n[g]),
      .sram_oe_n  (oe_n[g])
    );

    // Asynchronous SRAM
    logic [15:0] smem [262144];
    assign dq_i[g] = !oe_n[g] ? smem[sram_addr[g]] : 16'h0000;
    always @(posedge clk) if (!we_n[g] && dq_oe[g]) smem[sram_addr[g]] <= dq_o[g];

    // Reference: t counts cycles since acceptance (0 = idle, 1..2W = phases, TD = done)
    logic [31:0] ref_mem [131072];
    int          m_t = 0;
    logic [16:0] m_widx = '0;
    logic [31:0] m_wd = '0;
    logic        m_wr = 1'b0;
    logic [17:0] e_addr = '0;
    logic [15:0] e_dq = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    initial begin
      for (int i = 0; i < 131072; i++) ref_mem[i] = '0;
      for (int i = 0; i < 262144; i++) smem[i] = '0;
    end

    always @(posedge clk or negedge rst) begin : mdl
      logic [31:0] off;
      logic        bad;
      if (!rst) begin
        m_t = 0; e_addr = '0; e_dq = '0; m_rdata = '0; m_err = 1'b0; m_wr = 1'b0;
      end else if (m_t == 0) begin
        if (mem_r_en[g] || mem_w_en[g]) begin
          off    = addr[g] - 32'd1024;
          m_widx = off[18:2];
          m_wd   = wdata[g];
          m_wr   = mem_w_en[g];
          bad    = 1'b0;
`ifdef SRAM_RANGE_CHECK_EN
          bad = (off[31:19] != 0);
`endif
          if (bad) begin
            m_t   = TD;
            m_err = 1'b1;
            if (!m_wr) m_rdata = '0;
          end else begin
            m_t = 1;
          end
        end
      end else if (m_t == TD) begin
        m_t   = 0;
        m_err = 1'b0;
      end else begin
        m_t++;
        if (m_t == TD) begin
          if (m_wr) ref_mem[m_widx] = m_wd;
          else      m_rdata = ref_mem[m_widx];
        end
      end
      if (m_t >= 1 && m_t <= 2 * W) begin
        e_addr = {m_widx, (m_t > W)};
        if (m_wr) e_dq = (m_t > W) ? m_wd[31:16] : m_wd[15:0];
      end
    end

    always @(negedge clk) begin : cmp
      logic phase, req;
      phase = (m_t >= 1) && (m_t <= 2 * W);
      req   = mem_r_en[g] || mem_w_en[g];
      check("ready", g, ready[g], (m_t == 0 && !req) || (m_t == TD));
      check("sram_addr", g, sram_addr[g], e_addr);
      check("we_n", g, we_n[g], !(phase && m_wr));
      check("oe_n", g, oe_n[g], !(phase && !m_wr));
      check("dq_oe", g, dq_oe[g], phase && m_wr);
      check("dq_o", g, dq_o[g], e_dq);
      check("err", g, err[g], m_err);
      if (m_t == 0 || m_t == TD) check("rdata", g, rdata[g], m_rdata);
    end
  end

  // Presents a request (called just after a rising edge), waits for ready,
  // traces the SRAM strobes, then returns just after the edge leaving DONE.
  task automatic access(input int lane, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit clr);
    bit done_ok;
    if (clr) begin
      tr_addr.delete();
      tr_dq.delete();
      n_wr = 0;
      n_rd = 0;
    end
    mem_r_en[lane] = r;
    mem_w_en[lane] = w;
    addr[lane]     = a;
    wdata[lane]    = d;
    n_low   = 0;
    done_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!we_n[lane]) begin
        tr_addr.push_back(32'(sram_addr[lane]));
        tr_dq.push_back(32'(dq_o[lane]));
        n_wr++;
      end
      if (!oe_n[lane]) begin
        tr_addr.push_back(32'(sram_addr[lane]));
        n_rd++;
      end
      if (ready[lane]) begin
        done_ok    = 1'b1;
        last_rdata = rdata[lane];
        last_err   = err[lane];
        break;
      end
      n_low++;
    end
    if (!done_ok) check("ready_timeout", lane, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int lane);
    mem_r_en[lane] = 1'b0;
    mem_w_en[lane] = 1'b0;
  endtask

  task automatic check_seq4(input string nm, input int lane, input bit use_dq,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    check({nm, "_len"}, lane, use_dq ? tr_dq.size() : tr_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (use_dq && i < tr_dq.size()) check(nm, lane, tr_dq[i], e[i]);
      else if (!use_dq && i < tr_addr.size()) check(nm, lane, tr_addr[i], e[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_r_en[i] = 1'b0; mem_w_en[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", 0, ready[0], 1);
    check("rst_rdata", 0, rdata[0], 0);
    check("rst_we_n", 0, we_n[0], 1);
    check("rst_oe_n", 0, oe_n[0], 1);
    check("rst_sram_addr", 0, sram_addr[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Store 0xDEADBEEF at 1032: halfwords 4 then 5, 2 cycles each
    access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b1);
    idle(0);
    check("st_ready_low", 0, n_low, 5);
    check_seq4("st_addr", 0, 1'b0, 4, 4, 5, 5);
    check_seq4("st_dq", 0, 1'b1, 32'hBEEF, 32'hBEEF, 32'hDEAD, 32'hDEAD);

    // Load it back
    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
    idle(0);
    check("ld_ready_low", 0, n_low, 5);
    check("ld_rdata", 0, last_rdata, 32'hDEADBEEF);
    check_seq4("ld_addr", 0, 1'b0, 4, 4, 5, 5);

    // Both enables: treated as a store, rdata untouched
    access(0, 1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b1);
    idle(0);
    check("both_rdata", 0, last_rdata, 32'hDEADBEEF);
    check("both_n_wr", 0, n_wr, 4);
    check("both_n_rd", 0, n_rd, 0);
    access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b1);
    idle(0);
    check("both_readback", 0, last_rdata, 32'h12345678);

    // Back-to-back on the W=1 lane: no dead cycle after DONE
    access(1, 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b1);
    check("b2b_st_low", 1, n_low, 3);
    access(1, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
    idle(1);
    check("b2b_ld_low", 1, n_low, 3);
    check_seq4("b2b_addr", 1, 1'b0, 4, 5, 6, 7);

    // Reset in the middle of LO
    mem_w_en[0] = 1'b1; addr[0] = 32'd2048; wdata[0] = 32'h11112222;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0);
    #1;
    check("mid_rst_ready", 0, ready[0], 1);
    check("mid_rst_we_n", 0, we_n[0], 1);
    check("mid_rst_dq_oe", 0, dq_oe[0], 0);
    check("mid_rst_addr", 0, sram_addr[0], 0);
    check("mid_rst_dq_o", 0, dq_o[0], 0);
    check("mid_rst_rdata", 0, rdata[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
    idle(0);
    check("post_rst_rdata", 0, last_rdata, 32'hDEADBEEF);

    // Out-of-range load: off = 0x80C00
    access(0, 1'b1, 1'b0, 32'h00081000, 32'h0, 1'b1);
    idle(0);
    check("rng_rdata", 0, last_rdata, 0);
`ifdef SRAM_RANGE_CHECK_EN
    check("rng_ready_low", 0, n_low, 1);
    check("rng_err", 0, last_err, 1);
    check("rng_strobes", 0, tr_addr.size(), 0);
`else
    check("rng_ready_low", 0, n_low, 5);
    check("rng_err", 0, last_err, 0);
    check_seq4("rng_addr", 0, 1'b0, 32'h600, 32'h600, 32'h601, 32'h601);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
